// File: rtl/cents_str_fmt.sv
// cents_str_fmt: turns an 8-bit cents value into a 12-character ASCII line
// "LLLL: $H.TO " for the OLED character interface (char 0 in [95:88]).
// Binary-to-BCD is done iteratively with double-dabble, one bit per clock.
// Optional build macro FMT_RANGE_CHK_EN: values above MAX_CENTS show
// "LLLL: ERR   " and raise err; without it err is constant 0.
module cents_str_fmt #(
  parameter int unsigned MAX_CENTS = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  lbl,
  input  logic [7:0]  cents,
  output logic        busy,
  output logic        str_valid,
  output logic [95:0] str,
  output logic        err
);

  localparam int unsigned BIN_W = 8;
  localparam int unsigned BCD_W = 12;
  localparam int unsigned CNT_W = 3;
  localparam int unsigned STR_W = 96;

  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_COL = 8'h3A;
  localparam logic [7:0] CH_DOL = 8'h24;
  localparam logic [7:0] CH_DOT = 8'h2E;
  localparam logic [7:0] CH_0   = 8'h30;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PACK  = 2'd2
  } state_t;

  state_t             state_q, state_n;
  logic [BIN_W-1:0]   bin_q, bin_n;
  logic [BCD_W-1:0]   bcd_q, bcd_n, bcd_adj;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [1:0]         lbl_q, lbl_n;
  logic               busy_n, valid_n, err_n;
  logic [STR_W-1:0]   str_n;
`ifdef FMT_RANGE_CHK_EN
  logic [BIN_W-1:0]   val_q, val_n;
`endif

  // Per-digit double-dabble correction in 4-bit arithmetic
  function automatic logic [3:0] add3(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Four-character label text
  function automatic logic [31:0] label_text(input logic [1:0] l);
    case (l)
      2'd0:    return 32'h534F_4441; // SODA
      2'd1:    return 32'h434F_494E; // COIN
      2'd2:    return 32'h544F_544C; // TOTL
      default: return 32'h4449_5350; // DISP
    endcase
  endfunction

  // Next-state, datapath and output decode
  always_comb begin
    state_n = state_q;
    bin_n   = bin_q;
    bcd_n   = bcd_q;
    cnt_n   = cnt_q;
    lbl_n   = lbl_q;
    busy_n  = busy;
    valid_n = 1'b0;
    str_n   = str;
    err_n   = err;
    bcd_adj = '0;
`ifdef FMT_RANGE_CHK_EN
    val_n   = val_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          bin_n   = cents;
          lbl_n   = lbl;
          bcd_n   = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = SHIFT;
`ifdef FMT_RANGE_CHK_EN
          val_n   = cents;
`endif
        end
      end

      SHIFT: begin
        bcd_adj        = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        {bcd_n, bin_n} = {bcd_adj, bin_q} << 1;
        cnt_n          = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(7)) begin
          state_n = PACK;
        end
      end

      PACK: begin
        str_n   = {label_text(lbl_q), CH_COL, CH_SP, CH_DOL,
                   CH_0 + {4'h0, bcd_q[11:8]}, CH_DOT,
                   CH_0 + {4'h0, bcd_q[7:4]},
                   CH_0 + {4'h0, bcd_q[3:0]}, CH_SP};
`ifdef FMT_RANGE_CHK_EN
        if (32'(val_q) > MAX_CENTS) begin
          str_n = {label_text(lbl_q), CH_COL, CH_SP, 8'h45, 8'h52, 8'h52,
                   CH_SP, CH_SP, CH_SP};
          err_n = 1'b1;
        end else begin
          err_n = 1'b0;
        end
`else
        // Constant: no comparator; only an out-of-range MAX_CENTS could set it
        err_n   = 1'(MAX_CENTS > 32'd255);
`endif
        valid_n = 1'b1;
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      cnt_q     <= '0;
      lbl_q     <= '0;
      busy      <= 1'b0;
      str_valid <= 1'b0;
      str       <= {12{CH_SP}};
      err       <= 1'b0;
`ifdef FMT_RANGE_CHK_EN
      val_q     <= '0;
`endif
    end else begin
      state_q   <= state_n;
      bin_q     <= bin_n;
      bcd_q     <= bcd_n;
      cnt_q     <= cnt_n;
      lbl_q     <= lbl_n;
      busy      <= busy_n;
      str_valid <= valid_n;
      str       <= str_n;
      err       <= err_n;
`ifdef FMT_RANGE_CHK_EN
      val_q     <= val_n;
`endif
    end
  end

endmodule

// File: tb/tb_cents_str_fmt.sv
// Testbench for cents_str_fmt: scoreboard of expected strings built from
// decimal arithmetic, a monitor that checks every str_valid pulse, directed
// cases followed by randomized requests with random spacing.
module tb_cents_str_fmt;

`ifdef FMT_RANGE_CHK_EN
  localparam int unsigned MAX_C = 200;
`else
  localparam int unsigned MAX_C = 255;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  lbl;
  logic [7:0]  cents;
  logic        busy;
  logic        str_valid;
  logic [95:0] str;
  logic        err;

  cents_str_fmt #(.MAX_CENTS(MAX_C)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .lbl       (lbl),
    .cents     (cents),
    .busy      (busy),
    .str_valid (str_valid),
    .str       (str),
    .err       (err)
  );

  typedef struct {
    logic [95:0] s;
    logic        e;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   n_chk   = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   next_ok = 0;

  localparam logic [95:0] SPACES = {12{8'h20}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: expected display line from decimal arithmetic on the value
  function automatic logic [95:0] exp_str(input int l, input int c);
    string       names[4];
    string       s;
    logic [7:0]  ch[12];
    logic [95:0] r;
    names = '{"SODA", "COIN", "TOTL", "DISP"};
    s = names[l];
    for (int i = 0; i < 4; i++) ch[i] = s[i];
    ch[4] = ":";
    ch[5] = " ";
    if (c > int'(MAX_C) && exp_err_en()) begin
      ch[6] = "E"; ch[7] = "R"; ch[8] = "R";
      ch[9] = " "; ch[10] = " "; ch[11] = " ";
    end else begin
      ch[6]  = "$";
      ch[7]  = 8'(48 + c / 100);
      ch[8]  = ".";
      ch[9]  = 8'(48 + (c / 10) % 10);
      ch[10] = 8'(48 + c % 10);
      ch[11] = " ";
    end
    for (int i = 0; i < 12; i++) r[95 - 8*i -: 8] = ch[i];
    return r;
  endfunction

  function automatic bit exp_err_en();
`ifdef FMT_RANGE_CHK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic exp_err(input int c);
    return logic'(exp_err_en() && c > int'(MAX_C));
  endfunction

  // Issue one start pulse; the model decides whether it is accepted
  task automatic do_start(input int l, input int c);
    exp_t e;
    @(negedge clk);
    lbl   = 2'(l);
    cents = 8'(c);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (cyc >= next_ok) begin
      e.s   = exp_str(l, c);
      e.e   = exp_err(c);
      e.due = cyc + 9;
      sb.push_back(e);
      next_ok = cyc + 10;
      chk("busy_after_start", 96'(busy), 96'(1));
    end
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Monitor: every valid pulse must match the oldest expected entry on time
  always @(negedge clk) begin
    exp_t e;
    if (!rst && str_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_valid: got str %h with empty scoreboard", str);
      end else begin
        e = sb.pop_front();
        chk("str",        str,        e.s);
        chk("err",        96'(err),   96'(e.e));
        chk("valid_time", 96'(cyc),   96'(e.due));
        chk("busy_at_done", 96'(busy), 96'(0));
      end
    end
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    lbl   = '0;
    cents = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy",  96'(busy),      96'(0));
    chk("rst_valid", 96'(str_valid), 96'(0));
    chk("rst_err",   96'(err),       96'(0));
    chk("rst_str",   str,            SPACES);

    // Single conversion with busy profile
    do_start(0, 75);
    repeat (9) @(negedge clk);
    chk("busy_at_E8",  96'(busy),      96'(1));
    chk("valid_at_E8", 96'(str_valid), 96'(0));
    gap(12);

    // Back-to-back, second start at E10
    do_start(1, 255);
    gap(9);
    do_start(2, 0);
    gap(12);

    // Start while busy is dropped
    do_start(0, 100);
    gap(3);
    do_start(3, 5);
    gap(12);

    // Reset mid-conversion aborts
    do_start(0, 25);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    next_ok = 0;
    chk("abort_str",   str,            SPACES);
    chk("abort_busy",  96'(busy),      96'(0));
    chk("abort_valid", 96'(str_valid), 96'(0));
    gap(12);
    chk("abort_str_held", str, SPACES);
    do_start(3, 25);
    gap(12);

    // Range boundary around MAX_CENTS
    do_start(0, 201);
    gap(12);
    chk("err_held", 96'(err), 96'(exp_err(201)));
    do_start(0, 200);
    gap(12);
    chk("err_after_200", 96'(err), 96'(0));

    // Randomized requests with random spacing
    for (int i = 0; i < 60; i++) begin
      gap(int'($urandom_range(0, 12)));
      do_start(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
    end
    gap(14);
    chk("scoreboard_drained", 96'(sb.size()), 96'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cents_str_fmt.md
Name: cents_str_fmt

Overview:
- Sequential formatter that turns an 8-bit cents value into a 12-character ASCII string for the 12-char OLED character interface (96-bit, char 0 in [95:88]).
- Sits between the soda machine datapath (price, coin and total registers) and the OLED driver.
- Converts binary to BCD iteratively with double-dabble, then packs a label, a dollar sign and a decimal point around the digits.
- Presents the packed string with a one-cycle valid pulse.

Parameters:
- MAX_CENTS, 255: largest value formatted normally. Used only when FMT_RANGE_CHK_EN is defined. Legal range 0..255.

Ports:
- clk  input  1  system clock (the 10 kHz FSM clock in the top level)
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request. Sampled only in IDLE.
- lbl  input  2  label select, captured with start: 0 "SODA", 1 "COIN", 2 "TOTL", 3 "DISP"
- cents  input  8  unsigned cents value, captured with start
- busy  output  1  high while a conversion is in progress
- str_valid  output  1  one-cycle pulse when str is updated
- str  output  96  formatted string; holds its last value until the next completion
- err  output  1  range-error flag (see Optional Feature)

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE, busy = 0, str_valid = 0, err = 0.
  - str = 12 ASCII spaces (0x20 repeated).
  - Captured lbl, cents and BCD scratch are cleared.
- States: IDLE -> SHIFT -> PACK -> IDLE.
- IDLE:
  - On start = 1 at edge E0, capture cents into an 8-bit shift register and lbl into a 2-bit register.
  - Clear the 12-bit BCD scratch (hundreds/tens/ones) and the 3-bit iteration counter.
  - Set busy = 1 and go to SHIFT.
- SHIFT, one iteration per edge, edges E1..E8:
  - Each BCD digit >= 5 gets +3.
  - Then {bcd, bin} shifts left by 1, with the binary MSB entering the ones LSB.
  - The counter increments. After the 8th iteration (counter wrapped 7->0), go to PACK.
- PACK, edge E9:
  - Write str and assert str_valid = 1 for exactly one cycle.
  - busy = 0 at the same edge. Return to IDLE.
- Latency:
  - start sampled at E0; str and str_valid change at E9.
  - Back-to-back: a new start may be accepted at E10, while str_valid is high.
- String layout, chars 0..11: L0 L1 L2 L3 ':' ' ' '$' H '.' T O ' '.
  - L0..L3 are the label characters.
  - H, T, O are the hundreds, tens and ones digits, each 0x30 + digit.
  - Hundreds is at most 2, so the output range is $0.00..$2.55.
  - Leading zeros are always shown.
- start while busy = 1 is ignored: no queueing, and lbl/cents changes have no effect.
- rst during SHIFT or PACK aborts immediately:
  - Returns to the reset state. str goes to spaces and no str_valid is issued.
- If str_valid and a new start coincide in the same cycle, the start is accepted normally.
- Digit add-3 correction uses 4-bit arithmetic per digit. No overflow is possible for 8-bit inputs.

Optional Feature:
- Macro: FMT_RANGE_CHK_EN.
- Defined:
  - At PACK, if the captured cents > MAX_CENTS, str = L0..L3 ':' ' ' 'E' 'R' 'R' ' ' ' ' ' '.
  - err = 1 is registered with str and held until the next completion or rst.
  - Otherwise err = 0 and the normal format applies.
  - Latency is unchanged.
- Not defined: no comparator is built, err is tied to 0, and all values 0..255 are formatted normally.

Test Plan:
1. rst held 2 cycles, then released -> busy = 0, str_valid = 0, err = 0, str = 96'h2020...20 (12 spaces).
2. start with lbl = 0, cents = 75 -> busy high for 9 edges; at E9 str = "SODA: $0.75 " (0x534F44413A2024302E373520) and str_valid high for exactly 1 cycle.
3. lbl = 1, cents = 255, then lbl = 2, cents = 0, back-to-back (second start at E10) -> "COIN: $2.55 " then "TOTL: $0.00 ", second valid at E19.
4. start with cents = 100; start again at E4 with lbl = 3, cents = 5 -> only one completion, at E9, with str = "SODA: $1.00 " (or matching lbl); the second request is dropped.
5. start with cents = 25; rst asserted at E5 -> no str_valid; str = spaces; the next start with lbl = 3, cents = 25 gives "DISP: $0.25 ".
6. FMT_RANGE_CHK_EN defined, MAX_CENTS = 200: cents = 201 -> "SODA: ERR   " with err = 1; then cents = 200 -> "SODA: $2.00 " with err = 0. Macro undefined: cents = 201 -> "SODA: $2.01 ", err = 0.
